// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer that owns HI/LO; 35 cycles from accept to result.
// Define HILO_MULDIV_SIGNED_EN for signed MULT/DIV; otherwise ops 00/10 behave as MULTU/DIVU.
module hilo_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            hilo_we,
  input  logic            hilo_sel,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              done_q, done_d;

  logic              accept;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0] result;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // acc holds {upper, lower} of the product, or {remainder, quotient} when dividing.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign rem_shift = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};

`ifdef HILO_MULDIV_SIGNED_EN
  logic is_signed_q, is_signed_d;
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic sa, sb;

  assign sa = is_signed_q & a_q[XLEN-1];
  assign sb = is_signed_q & b_q[XLEN-1];

  always_comb begin
    result = acc_q;
    if (!is_div_q) begin
      if (neg_quo_q) result = -acc_q;
    end else begin
      if (neg_rem_q) result[2*XLEN-1:XLEN] = -acc_q[2*XLEN-1:XLEN];
      if (neg_quo_q) result[XLEN-1:0]      = -acc_q[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_signed_q <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      is_signed_q <= is_signed_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = req_op[0];
  assign result     = acc_q;
`endif

  always_comb begin
    // NOTE: every _d starts as its hold value so no path through this block can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
`ifdef HILO_MULDIV_SIGNED_EN
    is_signed_d = is_signed_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif

    if (hilo_we && state_q == S_IDLE) begin
      if (hilo_sel) hi_d = hilo_wdata;
      else          lo_d = hilo_wdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = req_a;
          b_d      = req_b;
          is_div_d = req_op[1];
`ifdef HILO_MULDIV_SIGNED_EN
          is_signed_d = ~req_op[0];
`endif
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
`ifdef HILO_MULDIV_SIGNED_EN
        a_d       = sa ? -a_q : a_q;
        b_d       = sb ? -b_q : b_q;
        // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
        neg_quo_d = (sa ^ sb) & ~(is_div_q & (b_q == '0));
        neg_rem_d = sa;
`endif
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_div_q) begin
          a_d = a_q << 1;
          if (!rem_diff[XLEN]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          b_d   = b_q >> 1;
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = result[2*XLEN-1:XLEN];
        lo_d    = result[XLEN-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

endmodule
